// File: rtl/alu_command_issuer_if.sv
// ============================================================================
// Module  : alu_command_issuer_if
// Brief   : Request/response handshake bundle for the ALU command issuer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_command_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;      // {wide, funsel[4:0]}
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;   // {Z, C, N, O}
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_command_issuer.sv
// ============================================================================
// Module  : alu_command_issuer
// Brief   : Issues 16-bit ops (or ADD/ADC pairs for 32-bit adds) to an ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_command_issuer (
  input  wire logic             clk,
  input  wire logic             rst,
  alu_command_issuer_if.slave   bus,
  output logic [15:0]           o_alu_a,
  output logic [15:0]           o_alu_b,
  output logic [4:0]            o_alu_funsel,
  output logic                  o_alu_wf,
  input  wire logic [15:0]      i_alu_out,
  input  wire logic [3:0]       i_alu_flags
);

  localparam logic [4:0] c_FS_ADD  = 5'b10100;
  localparam logic [4:0] c_FS_ADC  = 5'b10101;
  localparam logic [4:0] c_FS_IDLE = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LO = 3'd1,
    S_CAPT_LO  = 3'd2,
    S_ISSUE_HI = 3'd3,
    S_CAPT_HI  = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic        r_err;
  logic        r_zlo;
  logic        w_accept;
  logic        w_legal;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  // Only the 32-bit add is defined for wide requests.
  assign w_legal  = !bus.req_op[5] || (bus.req_op[4:0] == c_FS_ADD);

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_result = r_result;
  assign bus.rsp_flags  = r_flags;
  assign bus.rsp_err    = r_err;

  always_comb begin
    w_next       = r_state;
    o_alu_a      = 16'h0000;
    o_alu_b      = 16'h0000;
    o_alu_funsel = c_FS_IDLE;
    o_alu_wf     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_legal ? S_ISSUE_LO : S_RESP;
      end
      S_ISSUE_LO: begin
        o_alu_a      = r_a[15:0];
        o_alu_b      = r_b[15:0];
        o_alu_funsel = r_op[4:0];
        o_alu_wf     = 1'b1;
        w_next       = S_CAPT_LO;
      end
      S_CAPT_LO: w_next = r_op[5] ? S_ISSUE_HI : S_RESP;
      S_ISSUE_HI: begin
        o_alu_a      = r_a[31:16];
        o_alu_b      = r_b[31:16];
        o_alu_funsel = c_FS_ADC;
        o_alu_wf     = 1'b1;
        w_next       = S_CAPT_HI;
      end
      S_CAPT_HI: w_next = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 6'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_flags  <= 4'd0;
      r_err    <= 1'b0;
      r_zlo    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.req_op;
            r_a      <= bus.req_a;
            r_b      <= bus.req_b;
            r_result <= 32'd0;
            r_flags  <= 4'd0;
            r_err    <= !w_legal;
          end
        end
        S_ISSUE_LO: r_result[15:0] <= i_alu_out;
        S_CAPT_LO: begin
          // ALU flags are registered on WF, so they are valid one cycle after the issue.
          if (r_op[5]) r_zlo   <= i_alu_flags[3];
          else         r_flags <= i_alu_flags;
        end
        S_ISSUE_HI: r_result[31:16] <= i_alu_out;
        S_CAPT_HI: r_flags <= {r_zlo & i_alu_flags[3], i_alu_flags[2:0]};
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_command_issuer.sv
// ============================================================================
// Module  : tb_alu_command_issuer
// Brief   : Self-checking bench with behavioural ALU and result scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_command_issuer;

  localparam logic [4:0] c_ADD = 5'b10100;
  localparam logic [4:0] c_ADC = 5'b10101;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
    int          lat;
    int          nwf;
    logic [36:0] p0;
    logic [36:0] p1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_fs;
  logic        alu_wf;
  logic [3:0]  alu_flags = 4'b0000;
  logic [3:0]  alu_nflags;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [36:0] wfq[$];
  logic [31:0] obs_res;
  logic [3:0]  obs_flg;
  logic        obs_err;
  int          obs_lat;

  alu_command_issuer_if bus ();

  alu_command_issuer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_funsel (alu_fs),
    .o_alu_wf     (alu_wf),
    .i_alu_out    (alu_out),
    .i_alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: combinational result, flags registered on WF
  function automatic logic [19:0] alu_eval(input logic [4:0] fs, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic        o;
    s = 17'd0;
    o = 1'b0;
    case (fs)
      c_ADD:   s = {1'b0, a} + {1'b0, b};
      c_ADC:   s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      default: s = {1'b0, a ^ b};
    endcase
    if (fs == c_ADD || fs == c_ADC) o = (a[15] == b[15]) && (s[15] != a[15]);
    return {(s[15:0] == 16'd0), s[16], s[15], o, s[15:0]};
  endfunction

  always_comb {alu_nflags, alu_out} = alu_eval(alu_fs, alu_a, alu_b, alu_flags[2]);
  always @(posedge clk) if (alu_wf) alu_flags <= alu_nflags;
  always @(negedge clk) if (alu_wf) wfq.push_back({alu_fs, alu_a, alu_b});

  function automatic exp_t predict(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [15:0] x;
    e.p0 = {op[4:0], a[15:0], b[15:0]};
    e.p1 = {c_ADC, a[31:16], b[31:16]};
    e.err = 1'b0;
    if (op[5] && op[4:0] != c_ADD) begin
      e.res = 32'd0; e.flg = 4'd0; e.err = 1'b1; e.lat = 1; e.nwf = 0;
    end else if (op[5]) begin
      s = {1'b0, a} + {1'b0, b};
      e.res = s[31:0];
      e.flg = {(s[31:0] == 32'd0), s[32], s[31], (a[31] == b[31]) && (s[31] != a[31])};
      e.lat = 5; e.nwf = 2;
    end else if (op[4:0] == c_ADD) begin
      s = {17'd0, a[15:0]} + {17'd0, b[15:0]};
      e.res = {16'd0, s[15:0]};
      e.flg = {(s[15:0] == 16'd0), s[16], s[15], (a[15] == b[15]) && (s[15] != a[15])};
      e.lat = 3; e.nwf = 1;
    end else begin
      x = a[15:0] ^ b[15:0];
      e.res = {16'd0, x};
      e.flg = {(x == 16'd0), 1'b0, x[15], 1'b0};
      e.lat = 3; e.nwf = 1;
    end
    return e;
  endfunction

  task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    sb.push_back(predict(op, a, b));
    @(posedge clk); #1;
    wfq.delete();
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    cnt = 0;
    while (!bus.req_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    total++;
    if (!bus.req_ready) begin bad++; $display("FAIL req_ready_timeout got=0 exp=1"); end
    @(posedge clk);
    obs_lat = 1;
    #1;
    bus.req_valid = 1'b0; bus.req_op = ~op; bus.req_a = ~a; bus.req_b = ~b;
    while (!bus.rsp_valid && obs_lat < 20) begin @(posedge clk); obs_lat++; #1; end
    total++;
    if (!bus.rsp_valid) begin bad++; $display("FAIL rsp_valid_timeout got=0 exp=1"); end
    obs_res = bus.rsp_result;
    obs_flg = bus.rsp_flags;
    obs_err = bus.rsp_err;
  endtask

  task automatic rsp_done();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (alu_wf !== 1'b0) begin bad++; $display("FAIL reset_alu_wf got=%b exp=0", alu_wf); end
    total++; if (bus.rsp_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.rsp_result); end
    total++; if (bus.rsp_flags !== 4'd0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", bus.rsp_flags); end
    total++; if ({alu_fs, alu_a, alu_b} !== {5'b10000, 32'd0}) begin
      bad++; $display("FAIL reset_alu_bus got=%h/%h/%h exp=10/0/0", alu_fs, alu_a, alu_b);
    end
  endtask

  task automatic test_narrow();
    logic [5:0]  ops[5] = '{{1'b0, c_ADD}, {1'b0, c_ADD}, {1'b0, c_ADD}, {1'b0, c_ADD}, 6'b000111};
    logic [31:0] as[5]  = '{32'h0000_0001, 32'h0000_7FFF, 32'h0000_FFFF, 32'hABCD_1234, 32'h0000_F0F0};
    logic [31:0] bs[5]  = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h5555_0001, 32'h0000_F0F0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      do_req(ops[i], as[i], bs[i]);
      e = sb.pop_front();
      total++; if (obs_res !== e.res) begin bad++; $display("FAIL narrow_result[%0d] got=%h exp=%h", i, obs_res, e.res); end
      total++; if (obs_flg !== e.flg) begin bad++; $display("FAIL narrow_flags[%0d] got=%b exp=%b", i, obs_flg, e.flg); end
      total++; if (obs_err !== e.err) begin bad++; $display("FAIL narrow_err[%0d] got=%b exp=%b", i, obs_err, e.err); end
      total++; if (obs_lat != e.lat) begin bad++; $display("FAIL narrow_latency[%0d] got=%0d exp=%0d", i, obs_lat, e.lat); end
      total++; if (wfq.size() != e.nwf) begin bad++; $display("FAIL narrow_wf_count[%0d] got=%0d exp=%0d", i, wfq.size(), e.nwf); end
      else if (wfq[0] !== e.p0) begin bad++; $display("FAIL narrow_wf_bus[%0d] got=%h exp=%h", i, wfq[0], e.p0); end
      rsp_done();
    end
  endtask

  task automatic test_wide();
    logic [31:0] as[3] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_8000};
    logic [31:0] bs[3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_8000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      do_req({1'b1, c_ADD}, as[i], bs[i]);
      e = sb.pop_front();
      total++; if (obs_res !== e.res) begin bad++; $display("FAIL wide_result[%0d] got=%h exp=%h", i, obs_res, e.res); end
      total++; if (obs_flg !== e.flg) begin bad++; $display("FAIL wide_flags[%0d] got=%b exp=%b", i, obs_flg, e.flg); end
      total++; if (obs_err !== e.err) begin bad++; $display("FAIL wide_err[%0d] got=%b exp=%b", i, obs_err, e.err); end
      total++; if (obs_lat != e.lat) begin bad++; $display("FAIL wide_latency[%0d] got=%0d exp=%0d", i, obs_lat, e.lat); end
      total++; if (wfq.size() != e.nwf) begin bad++; $display("FAIL wide_wf_count[%0d] got=%0d exp=%0d", i, wfq.size(), e.nwf); end
      else if (wfq[0] !== e.p0 || wfq[1] !== e.p1) begin
        bad++; $display("FAIL wide_wf_bus[%0d] got=%h,%h exp=%h,%h", i, wfq[0], wfq[1], e.p0, e.p1);
      end
      rsp_done();
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    do_req(6'b100111, 32'h1234_5678, 32'h9ABC_DEF0);
    e = sb.pop_front();
    total++; if (obs_err !== e.err) begin bad++; $display("FAIL illegal_err got=%b exp=%b", obs_err, e.err); end
    total++; if (obs_res !== e.res) begin bad++; $display("FAIL illegal_result got=%h exp=%h", obs_res, e.res); end
    total++; if (obs_flg !== e.flg) begin bad++; $display("FAIL illegal_flags got=%b exp=%b", obs_flg, e.flg); end
    total++; if (obs_lat != e.lat) begin bad++; $display("FAIL illegal_latency got=%0d exp=%0d", obs_lat, e.lat); end
    total++; if (wfq.size() != e.nwf) begin bad++; $display("FAIL illegal_wf_count got=%0d exp=%0d", wfq.size(), e.nwf); end
    rsp_done();
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_req({1'b1, c_ADD}, 32'h1234_FFFF, 32'h0001_0001);
    e = sb.pop_front();
    total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
      bad++; $display("FAIL stall_rsp got=%h/%b exp=%h/%b", obs_res, obs_flg, e.res, e.flg);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_result !== e.res ||
          bus.rsp_flags !== e.flg || bus.rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got v=%b rdy=%b res=%h flg=%b err=%b exp v=1 rdy=0 res=%h flg=%b err=0",
                 c, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags, bus.rsp_err, e.res, e.flg);
      end
    end
    rsp_done();
    total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release got rdy=%b v=%b exp rdy=1 v=0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    @(posedge clk); #1;
    bus.req_op = {1'b0, c_ADD}; bus.req_a = 32'd5; bus.req_b = 32'd6; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (alu_wf !== 1'b0) begin bad++; $display("FAIL abort_alu_wf got=%b exp=0", alu_wf); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_rsp_valid got=%0d cycles high exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [5:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? {1'b0, c_ADD} : {1'b1, c_ADD};
      a  = $urandom;
      b  = $urandom;
      do_req(op, a, b);
      e = sb.pop_front();
      total++; if (obs_res !== e.res || obs_flg !== e.flg || obs_lat != e.lat) begin
        bad++; $display("FAIL b2b[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, obs_res, obs_flg, obs_lat, e.res, e.flg, e.lat);
      end
      rsp_done();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 6'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_narrow();
    test_wide();
    test_illegal();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
